// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the rv32i fetch/execute sequencer.
package fetch_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, EXECUTE, MEM_WAIT} fetch_state_t;
   localparam int unsigned PC_STEP = 4;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the sequencer and imem / decode / dmem.
interface fetch_ctrl_if #(parameter int ADDRESS = 32) ();
   logic               imem_valid;
   logic               is_mem;
   logic               redirect;
   logic [ADDRESS-1:0] redirect_addr;
   logic               dm_valid;
   logic [ADDRESS-1:0] pc;
   logic [ADDRESS-1:0] pre_pc;
   logic               imem_req;
   logic               instr_valid;
   logic               dmem_req;
   logic               commit;
   logic               timeout;

   modport master (
      input  imem_valid, is_mem, redirect, redirect_addr, dm_valid,
      output pc, pre_pc, imem_req, instr_valid, dmem_req, commit, timeout
   );
   modport slave (
      output imem_valid, is_mem, redirect, redirect_addr, dm_valid,
      input  pc, pre_pc, imem_req, instr_valid, dmem_req, commit, timeout
   );
endinterface

// File: rtl/fetch_wait_timer.sv
// Saturating MEM_WAIT cycle counter; hit fires on the cycle the count reaches TIMEOUT.
module fetch_wait_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic hit
);
   localparam logic [15:0] LIMIT = 16'(TIMEOUT);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && cnt_q != LIMIT)
         cnt_d = cnt_q + 16'd1;
   end

   // Combinational so the flag sets on the same edge the count reaches TIMEOUT.
   assign hit = en && !clr && (cnt_q == LIMIT - 16'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
endmodule

// File: rtl/fetch_ctrl.sv
// Multi-cycle fetch/execute sequencer: owns pc/pre_pc, issues imem/dmem requests, pulses commit.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int          ADDRESS   = 32,
   parameter logic [31:0] RESET_VEC = 32'h0,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic          clk,
   input  logic          rst,
   fetch_ctrl_if.master  bus
);
   localparam logic [ADDRESS-1:0] RST_PC = RESET_VEC[ADDRESS-1:0];
   localparam logic [ADDRESS-1:0] STEP   = ADDRESS'(PC_STEP);
   localparam logic [ADDRESS-1:0] ALIGN  = ~ADDRESS'(3);

   fetch_state_t       state_q, state_d;
   logic [ADDRESS-1:0] pc_q, pc_d, pre_pc_q, pre_pc_d;
   logic               timeout_q, timeout_d;
   logic               commit;
   logic               tmr_clr, tmr_en, tmr_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     state_d = FETCH;
         FETCH:    if (bus.imem_valid) state_d = EXECUTE;
         EXECUTE:  state_d = bus.is_mem ? MEM_WAIT : FETCH;
         MEM_WAIT: if (bus.dm_valid) state_d = FETCH;
         default:  state_d = IDLE;
      endcase
   end

   // Moore strobes decode straight from state; commit also looks at the inputs.
   always_comb begin
      bus.imem_req    = (state_q == FETCH);
      bus.instr_valid = (state_q == EXECUTE) || (state_q == MEM_WAIT);
      bus.dmem_req    = (state_q == MEM_WAIT);
      commit          = ((state_q == EXECUTE) && !bus.is_mem) ||
                        ((state_q == MEM_WAIT) && bus.dm_valid);
   end

   assign tmr_clr = (state_q == EXECUTE) && bus.is_mem;
   assign tmr_en  = (state_q == MEM_WAIT) && !bus.dm_valid;

   fetch_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (tmr_clr),
      .en  (tmr_en),
      .hit (tmr_hit)
   );

   always_comb begin
      pc_d      = pc_q;
      pre_pc_d  = pre_pc_q;
      timeout_d = timeout_q | tmr_hit;
      if (commit) begin
         pre_pc_d = pc_q;
         if ((state_q == EXECUTE) && bus.redirect)
            pc_d = bus.redirect_addr & ALIGN;
         else
            pc_d = pc_q + STEP;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q      <= RST_PC;
         pre_pc_q  <= RST_PC;
         timeout_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         pre_pc_q  <= pre_pc_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.pc      = pc_q;
   assign bus.pre_pc  = pre_pc_q;
   assign bus.commit  = commit;
   assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl: TIMEOUT=4 instance plus a wrap-around instance.
module tb_fetch_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fetch_ctrl_if #(.ADDRESS(32)) if0 ();
   fetch_ctrl_if #(.ADDRESS(32)) if1 ();

   fetch_ctrl #(.ADDRESS(32), .RESET_VEC(32'h0), .TIMEOUT(4)) dut0 (
      .clk(clk), .rst(rst), .bus(if0.master));
   fetch_ctrl #(.ADDRESS(32), .RESET_VEC(32'hFFFF_FFFC), .TIMEOUT(255)) dut1 (
      .clk(clk), .rst(rst), .bus(if1.master));

   typedef struct {
      logic        iv, im, rd;
      logic [31:0] ra;
      logic        dv;
      logic [31:0] pc, ppc;
      logic        ireq, ivld, dreq, com, to;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   row   = -1;

   function automatic vec_t mk(logic iv, logic im, logic rd, logic [31:0] ra, logic dv,
                               logic [31:0] pc, logic [31:0] ppc, logic ireq, logic ivld,
                               logic dreq, logic com, logic to);
      vec_t v;
      v.iv = iv; v.im = im; v.rd = rd; v.ra = ra; v.dv = dv;
      v.pc = pc; v.ppc = ppc; v.ireq = ireq; v.ivld = ivld;
      v.dreq = dreq; v.com = com; v.to = to;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (row %0d): got %h expected %h", nm, row, act, exp);
      end
   endtask

   task automatic chk_all0(vec_t v);
      chk("pc", if0.pc, v.pc);
      chk("pre_pc", if0.pre_pc, v.ppc);
      chk("imem_req", 32'(if0.imem_req), 32'(v.ireq));
      chk("instr_valid", 32'(if0.instr_valid), 32'(v.ivld));
      chk("dmem_req", 32'(if0.dmem_req), 32'(v.dreq));
      chk("commit", 32'(if0.commit), 32'(v.com));
      chk("timeout", 32'(if0.timeout), 32'(v.to));
   endtask

   initial begin
      if0.imem_valid = 0; if0.is_mem = 0; if0.redirect = 0; if0.redirect_addr = 0; if0.dm_valid = 0;
      if1.imem_valid = 0; if1.is_mem = 0; if1.redirect = 0; if1.redirect_addr = 0; if1.dm_valid = 0;

      //        iv im rd ra            dv   pc      pre_pc  ireq ivld dreq com to
      tbl.push_back(mk(1,0,0,32'h0,    0, 32'h0,   32'h0,   0,0,0,0,0)); // IDLE
      tbl.push_back(mk(1,0,0,32'h0,    0, 32'h0,   32'h0,   1,0,0,0,0));
      tbl.push_back(mk(1,0,0,32'h0,    0, 32'h0,   32'h0,   0,1,0,1,0));
      tbl.push_back(mk(1,0,0,32'h0,    0, 32'h4,   32'h0,   1,0,0,0,0));
      tbl.push_back(mk(1,0,0,32'h0,    0, 32'h4,   32'h0,   0,1,0,1,0));
      tbl.push_back(mk(1,0,0,32'h0,    0, 32'h8,   32'h4,   1,0,0,0,0));
      tbl.push_back(mk(1,0,1,32'h103,  0, 32'h8,   32'h4,   0,1,0,1,0)); // redirect
      tbl.push_back(mk(0,0,0,32'h0,    0, 32'h100, 32'h8,   1,0,0,0,0)); // fetch stall
      tbl.push_back(mk(1,0,0,32'h0,    0, 32'h100, 32'h8,   1,0,0,0,0));
      tbl.push_back(mk(1,0,1,32'h12,   0, 32'h100, 32'h8,   0,1,0,1,0)); // redirect to 0x10
      tbl.push_back(mk(1,0,0,32'h0,    0, 32'h10,  32'h100, 1,0,0,0,0));
      tbl.push_back(mk(1,1,1,32'h200,  0, 32'h10,  32'h100, 0,1,0,0,0)); // load + ignored redirect
      tbl.push_back(mk(1,0,1,32'h300,  0, 32'h10,  32'h100, 0,1,1,0,0));
      tbl.push_back(mk(1,0,0,32'h0,    0, 32'h10,  32'h100, 0,1,1,0,0));
      tbl.push_back(mk(1,0,0,32'h0,    0, 32'h10,  32'h100, 0,1,1,0,0));
      tbl.push_back(mk(0,0,0,32'h0,    1, 32'h10,  32'h100, 0,1,1,1,0)); // dm_valid on 4th cycle
      tbl.push_back(mk(1,0,0,32'h0,    1, 32'h14,  32'h10,  1,0,0,0,0)); // stray dm_valid
      tbl.push_back(mk(1,1,0,32'h0,    0, 32'h14,  32'h10,  0,1,0,0,0));
      tbl.push_back(mk(0,0,0,32'h0,    0, 32'h14,  32'h10,  0,1,1,0,0));
      tbl.push_back(mk(0,0,0,32'h0,    0, 32'h14,  32'h10,  0,1,1,0,0));
      tbl.push_back(mk(0,0,0,32'h0,    0, 32'h14,  32'h10,  0,1,1,0,0));
      tbl.push_back(mk(0,0,0,32'h0,    0, 32'h14,  32'h10,  0,1,1,0,0));
      tbl.push_back(mk(0,0,0,32'h0,    0, 32'h14,  32'h10,  0,1,1,0,1)); // timeout set
      tbl.push_back(mk(0,0,0,32'h0,    1, 32'h14,  32'h10,  0,1,1,1,1)); // late completion
      tbl.push_back(mk(0,0,0,32'h0,    0, 32'h18,  32'h14,  1,0,0,0,1));
      tbl.push_back(mk(0,0,0,32'h0,    0, 32'h18,  32'h14,  1,0,0,0,1));
      tbl.push_back(mk(1,0,0,32'h0,    0, 32'h18,  32'h14,  1,0,0,0,1));
      tbl.push_back(mk(1,1,0,32'h0,    0, 32'h18,  32'h14,  0,1,0,0,1));
      tbl.push_back(mk(0,0,0,32'h0,    0, 32'h18,  32'h14,  0,1,1,0,1)); // MEM_WAIT

      repeat (2) @(negedge clk);
      #1;
      chk_all0(mk(0,0,0,0,0, 32'h0, 32'h0, 0,0,0,0,0));
      chk("rst pc1", if1.pc, 32'hFFFF_FFFC);
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl[i]) begin
         row = i;
         if0.imem_valid = tbl[i].iv; if0.is_mem = tbl[i].im; if0.redirect = tbl[i].rd;
         if0.redirect_addr = tbl[i].ra; if0.dm_valid = tbl[i].dv;
         #1;
         chk_all0(tbl[i]);
         @(negedge clk);
      end

      // Asynchronous reset while dut0 sits in MEM_WAIT.
      row = 100;
      if0.imem_valid = 0; if0.is_mem = 0; if0.redirect = 0; if0.dm_valid = 0;
      #1 chk("pre-reset dmem_req", 32'(if0.dmem_req), 32'd1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst dmem_req", 32'(if0.dmem_req), 32'd0);
      chk("rst instr_valid", 32'(if0.instr_valid), 32'd0);
      chk("rst pc", if0.pc, 32'h0);
      chk("rst pre_pc", if0.pre_pc, 32'h0);
      chk("rst timeout", 32'(if0.timeout), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      row = 101;
      chk("idle imem_req", 32'(if0.imem_req), 32'd0);
      chk("idle pc", if0.pc, 32'h0);
      @(negedge clk);
      #1;
      row = 102;
      chk("resume imem_req", 32'(if0.imem_req), 32'd1);
      chk("resume timeout", 32'(if0.timeout), 32'd0);

      // Wrap-around on dut1, now in its first FETCH cycle.
      if1.imem_valid = 1;
      #1;
      row = 200;
      chk("wrap fetch pc", if1.pc, 32'hFFFF_FFFC);
      chk("wrap imem_req", 32'(if1.imem_req), 32'd1);
      @(negedge clk);
      if1.imem_valid = 0;
      #1;
      row = 201;
      chk("wrap commit", 32'(if1.commit), 32'd1);
      chk("wrap instr_valid", 32'(if1.instr_valid), 32'd1);
      @(negedge clk);
      #1;
      row = 202;
      chk("wrap pc", if1.pc, 32'h0);
      chk("wrap pre_pc", if1.pre_pc, 32'hFFFF_FFFC);
      chk("wrap imem_req2", 32'(if1.imem_req), 32'd1);
      chk("wrap commit2", 32'(if1.commit), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
